// File: rtl/elevator_request_scheduler_pkg.sv
// Shared types and constants for the elevator request scheduler.
// Defines package elev_pkg: state encoding, floor geometry, direction codes and floor mask helpers.
package elev_pkg;

    localparam int NFLOORS = 4;
    localparam int FLOOR_W = 2;
    localparam int TIMER_W = 8;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Top floor has no up button and bottom floor has no down button.
    localparam logic [NFLOORS-1:0] UP_BTN_MASK = 4'b0111;
    localparam logic [NFLOORS-1:0] DN_BTN_MASK = 4'b1110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2,
        DOOR    = 2'd3
    } state_t;

    function automatic logic [NFLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
        logic [NFLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < NFLOORS; i++)
            if (i > int'(f)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [NFLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
        logic [NFLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < NFLOORS; i++)
            if (i < int'(f)) m[i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/elevator_request_scheduler_timer.sv
// Loadable down-counter advanced only by timebase ticks; used for travel and door timing.
module elev_tick_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Load has priority so a restart on the same cycle as a tick always yields a full period.
    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (enable && tick && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/elevator_request_scheduler.sv
// Four-floor elevator call latching and travel/door scheduling FSM.
// Optional macro ELEV_DOOR_HOLD_EN adds a door_hold input that keeps the door open.
module elevator_request_scheduler
    import elev_pkg::*;
#(
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TICKS   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       run,
    input  logic [3:0] hall_up,
    input  logic [3:0] hall_dn,
    input  logic [3:0] car_call,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic       door_hold,
`endif
    output logic [1:0] floor,
    output logic [1:0] state,
    output logic       door_open,
    output logic [3:0] pending
);

    state_t cur_state;
    logic   last_dir;

    logic [NFLOORS-1:0] up_lat, dn_lat, car_lat, all_lat;
    logic [NFLOORS-1:0] up_btn, dn_btn, floor_bit, block_set;
    logic [NFLOORS-1:0] clr_up, clr_dn, clr_car;

    logic [TIMER_W-1:0] travel_count, door_count;
    logic               travel_zero, door_zero;
    logic               travel_load, travel_en, door_load, door_en;

    logic               moving, move_up, at_floor, calls_above, calls_below;
    logic [FLOOR_W-1:0] next_floor;
    logic [NFLOORS-1:0] next_bit;
    logic               ahead_next, arrive, arrive_stop, arrive_go;
    logic               idle_door, idle_up, idle_dn, enter_door;
    logic               door_btn, hold_reload, door_reload, door_close;
    logic               idle_dir, svc_dir, svc_ahead;
    logic [FLOOR_W-1:0] svc_floor;
    logic [NFLOORS-1:0] svc_bit;

`ifdef ELEV_DOOR_HOLD_EN
    assign hold_reload = (cur_state == DOOR) && door_hold;
`else
    assign hold_reload = 1'b0;
`endif

    assign state   = cur_state;
    assign pending = all_lat;

    // Decode every transition once so the FSM, timers and latch clears agree.
    always_comb begin
        all_lat     = up_lat | dn_lat | car_lat;
        up_btn      = hall_up & UP_BTN_MASK;
        dn_btn      = hall_dn & DN_BTN_MASK;
        floor_bit   = 4'b0001 << floor;
        at_floor    = |(all_lat & floor_bit);
        calls_above = |(all_lat & above_mask(floor));
        calls_below = |(all_lat & below_mask(floor));

        moving      = (cur_state == MOVE_UP) || (cur_state == MOVE_DN);
        move_up     = (cur_state == MOVE_UP);
        next_floor  = move_up ? floor + 1'b1 : floor - 1'b1;
        next_bit    = 4'b0001 << next_floor;
        ahead_next  = |(all_lat & (move_up ? above_mask(next_floor) : below_mask(next_floor)));
        arrive      = run && moving && tick &&
                      ((travel_count == TIMER_W'(1)) || travel_zero);
        arrive_stop = car_lat[next_floor] ||
                      (move_up ? up_lat[next_floor] : dn_lat[next_floor]) ||
                      ((|(all_lat & next_bit)) && !ahead_next);
        arrive_go   = !arrive_stop && ahead_next;

        idle_door   = run && (cur_state == IDLE) && at_floor;
        idle_up     = run && (cur_state == IDLE) && !at_floor && calls_above &&
                      ((last_dir == DIR_UP) || !calls_below);
        idle_dn     = run && (cur_state == IDLE) && !at_floor && !idle_up && calls_below;
        enter_door  = idle_door || (arrive && arrive_stop);

        door_btn    = (cur_state == DOOR) && (|((up_btn | dn_btn | car_call) & floor_bit));
        door_reload = door_btn || hold_reload;
        door_close  = run && (cur_state == DOOR) && !door_reload &&
                      ((tick && (door_count == TIMER_W'(1))) || door_zero);

        // From IDLE keep the last direction unless only the opposite hall call waits here.
        idle_dir    = last_dir ? (up_lat[floor] || !dn_lat[floor])
                               : (up_lat[floor] && !dn_lat[floor]);
        svc_floor   = (cur_state == IDLE) ? floor : next_floor;
        svc_dir     = (cur_state == IDLE) ? idle_dir : move_up;
        svc_bit     = 4'b0001 << svc_floor;
        svc_ahead   = |(all_lat & (svc_dir ? above_mask(svc_floor) : below_mask(svc_floor)));

        clr_car     = enter_door ? svc_bit : '0;
        clr_up      = (enter_door && (svc_dir || !svc_ahead)) ? svc_bit : '0;
        clr_dn      = (enter_door && (!svc_dir || !svc_ahead)) ? svc_bit : '0;
        block_set   = (cur_state == DOOR) ? floor_bit : '0;

        travel_load = idle_up || idle_dn || (arrive && arrive_go);
        travel_en   = run && moving;
        door_load   = enter_door || door_reload;
        door_en     = run && (cur_state == DOOR);
    end

    elev_tick_timer #(.WIDTH(TIMER_W)) travel_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (travel_load),
        .load_value (TIMER_W'(TRAVEL_TICKS)),
        .tick       (tick),
        .enable     (travel_en),
        .count      (travel_count),
        .zero       (travel_zero)
    );

    elev_tick_timer #(.WIDTH(TIMER_W)) door_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (door_load),
        .load_value (TIMER_W'(DOOR_TICKS)),
        .tick       (tick),
        .enable     (door_en),
        .count      (door_count),
        .zero       (door_zero)
    );

    // A new press beats a same-cycle service clear, except presses at the open door's floor.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state <= IDLE;
            floor     <= '0;
            last_dir  <= DIR_UP;
            door_open <= 1'b0;
            up_lat    <= '0;
            dn_lat    <= '0;
            car_lat   <= '0;
        end else begin
            up_lat  <= (up_lat & ~clr_up) | (up_btn & ~block_set);
            dn_lat  <= (dn_lat & ~clr_dn) | (dn_btn & ~block_set);
            car_lat <= (car_lat & ~clr_car) | (car_call & ~block_set);

            case (cur_state)
                IDLE: begin
                    if (idle_door) begin
                        cur_state <= DOOR;
                        door_open <= 1'b1;
                    end else if (idle_up) begin
                        cur_state <= MOVE_UP;
                        last_dir  <= DIR_UP;
                    end else if (idle_dn) begin
                        cur_state <= MOVE_DN;
                        last_dir  <= DIR_DN;
                    end
                end
                MOVE_UP, MOVE_DN: begin
                    if (arrive) begin
                        floor <= next_floor;
                        if (arrive_stop) begin
                            cur_state <= DOOR;
                            door_open <= 1'b1;
                        end else if (!arrive_go) begin
                            cur_state <= IDLE;
                        end
                    end
                end
                DOOR: begin
                    if (door_close) begin
                        cur_state <= IDLE;
                        door_open <= 1'b0;
                    end
                end
                default: begin
                    cur_state <= IDLE;
                    door_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboard bench for elevator_request_scheduler: directed scenarios push expected output changes,
// a negedge monitor pops and compares on every observed change of state/floor/door_open/pending.
module tb_elevator_request_scheduler;

    localparam int TICK_PERIOD = 4;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] fl;
        logic       dopen;
        logic [3:0] pend;
        int         tk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, tick, run;
    logic [3:0] hall_up, hall_dn, car_call;
    logic [1:0] floor, state;
    logic       door_open;
    logic [3:0] pending;
`ifdef ELEV_DOOR_HOLD_EN
    logic       door_hold;
`endif

    exp_t  exp_q[$];
    int    tick_cnt, phase;
    logic  tick_en, mon_en, timeout_flag;
    int    n_checks, n_fail;
    string scn_name;

    always #5 clk = ~clk;

    elevator_request_scheduler #(.TRAVEL_TICKS(4), .DOOR_TICKS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .run       (run),
        .hall_up   (hall_up),
        .hall_dn   (hall_dn),
        .car_call  (car_call),
`ifdef ELEV_DOOR_HOLD_EN
        .door_hold (door_hold),
`endif
        .floor     (floor),
        .state     (state),
        .door_open (door_open),
        .pending   (pending)
    );

    // Advance n cycles; drive the tick strobe just after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tick = 1'b0;
            if (tick_en) begin
                phase++;
                if (phase == TICK_PERIOD) begin
                    tick = 1'b1;
                    phase = 0;
                    tick_cnt++;
                end
            end
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] up, input logic [3:0] dn, input logic [3:0] car);
        hall_up  = up;
        hall_dn  = dn;
        car_call = car;
        step(1);
        hall_up  = '0;
        hall_dn  = '0;
        car_call = '0;
    endtask

    function automatic void expect_rec(input logic [1:0] st, input logic [1:0] fl,
                                       input logic dopen, input logic [3:0] pend, input int tk);
        exp_t e;
        e.st = st; e.fl = fl; e.dopen = dopen; e.pend = pend; e.tk = tk;
        exp_q.push_back(e);
    endfunction

    task automatic start_scenario(input string name);
        scn_name = name;
        rst = 1'b0;
        run = 1'b1;
        tick_en = 1'b0;
        hall_up = '0; hall_dn = '0; car_call = '0;
        step(2);
        rst = 1'b1;
        phase = 0;
        tick_cnt = 0;
        expect_rec(2'd0, 2'd0, 1'b0, 4'b0000, 0);
        mon_en = 1'b1;
    endtask

    task automatic wait_drain(input int max_steps);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_steps) begin
            step(1);
            n++;
        end
        step(8);
        if (exp_q.size() != 0) begin
            timeout_flag = 1'b1;
            @(negedge clk);
            #1;
            timeout_flag = 1'b0;
            exp_q.delete();
        end
        mon_en = 1'b0;
        tick_en = 1'b0;
        step(1);
    endtask

    task automatic check_output(input exp_t e, input logic [1:0] st, input logic [1:0] fl,
                                input logic dopen, input logic [3:0] pend, input int tk);
        n_checks++;
        if (st !== e.st || fl !== e.fl || dopen !== e.dopen || pend !== e.pend || tk != e.tk) begin
            n_fail++;
            $display("[TB] FAIL %s: got state=%0d floor=%0d door_open=%0b pending=%b tick=%0d, need state=%0d floor=%0d door_open=%0b pending=%b tick=%0d",
                     scn_name, st, fl, dopen, pend, tk, e.st, e.fl, e.dopen, e.pend, e.tk);
        end
    endtask

    // Monitor: every output change consumes one expected record.
    logic [8:0] prev_obs, obs;
    logic       was_en, timeout_seen;
    initial begin
        was_en = 1'b0;
        timeout_seen = 1'b0;
        prev_obs = '0;
    end
    always @(negedge clk) begin
        obs = {state, floor, door_open, pending};
        if (timeout_flag && !timeout_seen) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s drain_timeout: got %0d records left, need 0", scn_name, exp_q.size());
        end
        timeout_seen = timeout_flag;
        if (mon_en && (!was_en || obs != prev_obs)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL %s unexpected_change: got state=%0d floor=%0d door_open=%0b pending=%b tick=%0d, need no change",
                         scn_name, state, floor, door_open, pending, tick_cnt);
            end else begin
                check_output(exp_q.pop_front(), state, floor, door_open, pending, tick_cnt);
            end
        end
        was_en = mon_en;
        prev_obs = obs;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got simulation still running, need finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0; n_fail = 0;
        mon_en = 1'b0; timeout_flag = 1'b0; tick_en = 1'b0; tick = 1'b0;
        phase = 0; tick_cnt = 0;
        rst = 1'b0; run = 1'b1;
        hall_up = '0; hall_dn = '0; car_call = '0;
`ifdef ELEV_DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        step(2);

        // Car call to top floor: one floor per 4 ticks, door open 3 ticks.
        start_scenario("car_to_top");
        expect_rec(2'd0, 2'd0, 1'b0, 4'b1000, 0);
        expect_rec(2'd1, 2'd0, 1'b0, 4'b1000, 0);
        expect_rec(2'd1, 2'd1, 1'b0, 4'b1000, 4);
        expect_rec(2'd1, 2'd2, 1'b0, 4'b1000, 8);
        expect_rec(2'd3, 2'd3, 1'b1, 4'b0000, 12);
        expect_rec(2'd0, 2'd3, 1'b0, 4'b0000, 15);
        tick_en = 1'b1;
        apply_stimulus(4'b0000, 4'b0000, 4'b1000);
        wait_drain(300);

        // Up trip skips the opposite-direction call at 1, then serves it on the way down.
        start_scenario("mixed_calls");
        expect_rec(2'd0, 2'd0, 1'b0, 4'b1110, 0);
        expect_rec(2'd1, 2'd0, 1'b0, 4'b1110, 0);
        expect_rec(2'd1, 2'd1, 1'b0, 4'b1110, 4);
        expect_rec(2'd3, 2'd2, 1'b1, 4'b1010, 8);
        expect_rec(2'd0, 2'd2, 1'b0, 4'b1010, 11);
        expect_rec(2'd1, 2'd2, 1'b0, 4'b1010, 11);
        expect_rec(2'd3, 2'd3, 1'b1, 4'b0010, 15);
        expect_rec(2'd0, 2'd3, 1'b0, 4'b0010, 18);
        expect_rec(2'd2, 2'd3, 1'b0, 4'b0010, 18);
        expect_rec(2'd2, 2'd2, 1'b0, 4'b0010, 22);
        expect_rec(2'd3, 2'd1, 1'b1, 4'b0000, 26);
        expect_rec(2'd0, 2'd1, 1'b0, 4'b0000, 29);
        tick_en = 1'b1;
        apply_stimulus(4'b0100, 4'b0010, 4'b1000);
        wait_drain(500);

        // Call at the current floor opens the door; a re-press restarts the door period.
        start_scenario("door_reload");
        expect_rec(2'd0, 2'd0, 1'b0, 4'b0001, 0);
        expect_rec(2'd3, 2'd0, 1'b1, 4'b0000, 0);
        expect_rec(2'd0, 2'd0, 1'b0, 4'b0000, 5);
        tick_en = 1'b1;
        apply_stimulus(4'b0001, 4'b0000, 4'b0000);
        step(9);
        apply_stimulus(4'b0001, 4'b0000, 4'b0000);
        wait_drain(200);

        // run low for 5 ticks after 2 travel ticks: arrival 2 ticks after resuming.
        start_scenario("run_pause");
        expect_rec(2'd0, 2'd0, 1'b0, 4'b0010, 0);
        expect_rec(2'd1, 2'd0, 1'b0, 4'b0010, 0);
        expect_rec(2'd3, 2'd1, 1'b1, 4'b0000, 9);
        expect_rec(2'd0, 2'd1, 1'b0, 4'b0000, 12);
        tick_en = 1'b1;
        apply_stimulus(4'b0000, 4'b0000, 4'b0010);
        step(8);
        run = 1'b0;
        step(20);
        run = 1'b1;
        wait_drain(200);

        // Reset asserted while moving down from floor 2.
        start_scenario("reset_mid_move");
        expect_rec(2'd0, 2'd0, 1'b0, 4'b0100, 0);
        expect_rec(2'd1, 2'd0, 1'b0, 4'b0100, 0);
        expect_rec(2'd1, 2'd1, 1'b0, 4'b0100, 4);
        expect_rec(2'd3, 2'd2, 1'b1, 4'b0000, 8);
        expect_rec(2'd3, 2'd2, 1'b1, 4'b0001, 9);
        expect_rec(2'd0, 2'd2, 1'b0, 4'b0001, 11);
        expect_rec(2'd2, 2'd2, 1'b0, 4'b0001, 11);
        expect_rec(2'd0, 2'd0, 1'b0, 4'b0000, 12);
        tick_en = 1'b1;
        apply_stimulus(4'b0000, 4'b0000, 4'b0100);
        step(36);
        apply_stimulus(4'b0000, 4'b0000, 4'b0001);
        step(12);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        wait_drain(100);

`ifdef ELEV_DOOR_HOLD_EN
        // Door held for 10 ticks, then closes 3 ticks after release.
        start_scenario("door_hold");
        expect_rec(2'd0, 2'd0, 1'b0, 4'b0001, 0);
        expect_rec(2'd3, 2'd0, 1'b1, 4'b0000, 0);
        expect_rec(2'd0, 2'd0, 1'b0, 4'b0000, 13);
        tick_en = 1'b1;
        apply_stimulus(4'b0001, 4'b0000, 4'b0000);
        step(1);
        door_hold = 1'b1;
        step(39);
        door_hold = 1'b0;
        wait_drain(200);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 Parameter TRAVEL_TICKS, default 4, tick count per one-floor move.
REQ-002 Parameter DOOR_TICKS, default 3, tick count the door stays open.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst  input  1  reset rst, synchronous, active-low.
REQ-005 tick  input  1  one-cycle timebase strobe (1 Hz nominal); all timing counts ticks only.
REQ-006 run  input  1  start/stop; low freezes timers and FSM, calls still latched.
REQ-007 hall_up  input  4  level hall-up buttons per floor 0..3; bit 3 ignored.
REQ-008 hall_dn  input  4  level hall-down buttons per floor 0..3; bit 0 ignored.
REQ-009 car_call  input  4  in-car floor buttons 0..3.
REQ-010 floor  output  2  current floor.
REQ-011 state  output  2  FSM state: IDLE=0, MOVE_UP=1, MOVE_DN=2, DOOR=3.
REQ-012 door_open  output  1  high exactly while state==DOOR.
REQ-013 pending  output  4  OR of latched up, down and car calls per floor (LED drive).

Function
REQ-014 Any button high on a rising clk edge SHALL set its latch bit next cycle; latches clear only by service or reset.
REQ-015 IDLE: call latched at current floor -> DOOR next cycle; else any call above and (last direction up or none below) -> MOVE_UP; else any call below -> MOVE_DN; else remain IDLE.
REQ-016 MOVE_*: travel counter SHALL load TRAVEL_TICKS on entry and decrement on each tick while run=1; at zero, floor SHALL step +/-1 in the same cycle.
REQ-017 On arrival: enter DOOR if car call, hall call in travel direction, or any call at the floor with no calls further ahead; otherwise continue same direction with counter reloaded.
REQ-018 floor SHALL saturate at 0 and 3; MOVE_UP at floor 3 or MOVE_DN at floor 0 SHALL never be entered.
REQ-019 DOOR entry SHALL clear car call and the serviced-direction hall call at that floor (both hall calls if no calls remain ahead); door counter loads DOOR_TICKS.
REQ-020 A button for the current floor pressed during DOOR SHALL reload the door counter and not be latched.
REQ-021 Door counter zero SHALL return FSM to IDLE; re-evaluation per REQ-015 on the next cycle.
REQ-022 Latch set and clear for the same bit in one cycle: set wins, except per REQ-020.
REQ-023 run=0: state, floor, counters hold; tick ignored; resuming continues without reloading counters.
REQ-024 Last-direction register SHALL update on every MOVE entry; reset value up.

Reset
REQ-025 rst=0 on a clk edge SHALL force state=IDLE, floor=0, door_open=0, pending=0, all latches and counters 0, last direction up, regardless of state or run, including mid-move.

Configuration
REQ-026 Macro ELEV_DOOR_HOLD_EN defined: extra input door_hold (1 bit); while high in DOOR the door counter SHALL reload to DOOR_TICKS each cycle.
REQ-027 Macro undefined: no door_hold port; door closes after DOOR_TICKS ticks unconditionally (REQ-020 still applies).

Structure
REQ-028 Package elev_pkg SHALL hold the state enum, NFLOORS=4, floor width and direction constants.
REQ-029 Sub-module elev_tick_timer (load, tick, enable, count, zero flag) SHALL be instanced twice: travel and door.

Verification
REQ-030 Reset, car_call=4'b1000 with run=1 -> MOVE_UP, floor 1,2,3 at tick 4,8,12, then DOOR for 3 ticks, pending=0, IDLE.
REQ-031 At floor 0 MOVE_UP toward 3, hall_dn[1] and hall_up[2] latched -> no stop at 1, stop at 2, stop at 3, then MOVE_DN to 1.
REQ-032 hall_up[0] pressed in IDLE at floor 0 -> DOOR next cycle, no movement; re-press during DOOR -> door counter reloads to 3.
REQ-033 run=0 after 2 travel ticks for 5 ticks -> floor/state frozen; run=1 -> arrival after 2 more ticks.
REQ-034 rst=0 mid-MOVE_DN at floor 2 -> next cycle state=0, floor=0, pending=0.
REQ-035 ELEV_DOOR_HOLD_EN: door_hold high 10 ticks in DOOR -> door_open stays 1; released -> closes 3 ticks later.
